// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcode constants, class indices and the control-field values.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int NUM_CLS    = 9;
    localparam int CLS_R      = 0;
    localparam int CLS_I      = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_STORE  = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_JALR   = 6;
    localparam int CLS_LUI    = 7;
    localparam int CLS_AUIPC  = 8;

    typedef logic [NUM_CLS-1:0] cls_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_CMP   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_PASSB = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [2:0] imm_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } ctrl_out_t;

endpackage

// File: rtl/opcode_class_dec.sv
// Maps a 7-bit RV32I major opcode to a one-hot class, a legal flag and
// the immediate format the datapath must build for it.
module opcode_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       legal,
    output logic [2:0] imm_sel
);

    always_comb begin
        cls     = '0;
        imm_sel = IMM_I;
        case (opcode)
            OP_R:      cls[CLS_R] = 1'b1;
            OP_I:      cls[CLS_I] = 1'b1;
            OP_LOAD:   cls[CLS_LOAD] = 1'b1;
            OP_STORE: begin
                cls[CLS_STORE] = 1'b1;
                imm_sel        = IMM_S;
            end
            OP_BRANCH: begin
                cls[CLS_BRANCH] = 1'b1;
                imm_sel         = IMM_B;
            end
            OP_JAL: begin
                cls[CLS_JAL] = 1'b1;
                imm_sel      = IMM_J;
            end
            OP_JALR:   cls[CLS_JALR] = 1'b1;
            OP_LUI: begin
                cls[CLS_LUI] = 1'b1;
                imm_sel      = IMM_U;
            end
            OP_AUIPC: begin
                cls[CLS_AUIPC] = 1'b1;
                imm_sel        = IMM_U;
            end
            default: ;
        endcase
        legal = |cls;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Every output is a flop
// loaded with the controls of the state being entered on that edge.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [2:0] imm_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        op_q, op_d;
    logic [1:0]        cause_q, cause_d;
    ctrl_out_t         out_q, out_d;

    logic [6:0]        dec_op;
    cls_t              cls;
    logic              legal;
    logic [2:0]        dec_imm;
    logic              wait_expired;
    logic [CNT_W-1:0]  cnt_inc;
    logic              is_jump;

    // The decoder sees the live IR only while decoding; afterwards the latched copy.
    assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

    opcode_class_dec u_dec (
        .opcode  (dec_op),
        .cls     (cls),
        .legal   (legal),
        .imm_sel (dec_imm)
    );

    assign wait_expired = (cnt_q >= CNT_W'(MEM_TIMEOUT - 1));
    assign cnt_inc      = (cnt_q == CNT_W'(MEM_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    assign is_jump      = cls[CLS_JAL] | cls[CLS_JALR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            cause_q <= CAUSE_NONE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cause_q <= cause_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                    cnt_d   = '0;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (cls[CLS_LOAD] | cls[CLS_STORE]) state_d = ST_MEM;
                else if (cls[CLS_BRANCH])           state_d = ST_FETCH;
                else                                state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    cnt_d   = '0;
                    state_d = cls[CLS_STORE] ? ST_FETCH : ST_WB;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Branch and store complete on the edge leaving EXEC/MEM, so their PC
    // write and retire land in the first cycle of the following fetch.
    always_comb begin
        out_d = '0;
        case (state_d)
            ST_FETCH: begin
                out_d.imem_req = 1'b1;
                if (state_q == ST_EXEC) begin
                    out_d.pc_we  = 1'b1;
                    out_d.pc_src = branch_taken ? PC_IMM : PC_PLUS4;
                    out_d.retire = 1'b1;
                end else if (state_q == ST_MEM) begin
                    out_d.pc_we  = 1'b1;
                    out_d.pc_src = PC_PLUS4;
                    out_d.retire = 1'b1;
                end
            end
            ST_DECODE: out_d.ir_we = (state_q == ST_FETCH);
            ST_EXEC: begin
                out_d.imm_sel = dec_imm;
                if (cls[CLS_R]) out_d.alu_op = ALU_FUNCT;
                if (cls[CLS_I]) begin
                    out_d.alu_src_b = 1'b1;
                    out_d.alu_op    = ALU_FUNCT;
                end
                if (cls[CLS_LOAD] | cls[CLS_STORE]) begin
                    out_d.alu_src_b = 1'b1;
                    out_d.alu_op    = ALU_ADD;
                end
                if (cls[CLS_LUI]) out_d.alu_op = ALU_PASSB;
                if (cls[CLS_AUIPC]) begin
                    out_d.alu_src_a = 1'b1;
                    out_d.alu_src_b = 1'b1;
                    out_d.alu_op    = ALU_ADD;
                end
                if (cls[CLS_BRANCH]) out_d.alu_op = ALU_CMP;
                if (cls[CLS_JAL]) begin
                    out_d.pc_we  = 1'b1;
                    out_d.pc_src = PC_IMM;
                end
                if (cls[CLS_JALR]) begin
                    out_d.pc_we  = 1'b1;
                    out_d.pc_src = PC_JALR;
                end
            end
            ST_MEM: begin
                out_d.dmem_req = 1'b1;
                out_d.dmem_we  = cls[CLS_STORE];
                out_d.imm_sel  = dec_imm;
            end
            ST_WB: begin
                out_d.reg_we  = 1'b1;
                out_d.retire  = 1'b1;
                out_d.imm_sel = dec_imm;
                if (cls[CLS_LOAD])  out_d.wb_sel = WB_MEM;
                else if (is_jump)   out_d.wb_sel = WB_PC4;
                else                out_d.wb_sel = WB_ALU;
                if (!is_jump) begin
                    out_d.pc_we  = 1'b1;
                    out_d.pc_src = PC_PLUS4;
                end
            end
            ST_TRAP: begin
                out_d.trap       = 1'b1;
                out_d.trap_cause = cause_d;
            end
            default: ;
        endcase
    end

    assign imem_req   = out_q.imem_req;
    assign ir_we      = out_q.ir_we;
    assign dmem_req   = out_q.dmem_req;
    assign dmem_we    = out_q.dmem_we;
    assign pc_we      = out_q.pc_we;
    assign pc_src     = out_q.pc_src;
    assign imm_sel    = out_q.imm_sel;
    assign alu_src_a  = out_q.alu_src_a;
    assign alu_src_b  = out_q.alu_src_b;
    assign alu_op     = out_q.alu_op;
    assign reg_we     = out_q.reg_we;
    assign wb_sel     = out_q.wb_sel;
    assign retire     = out_q.retire;
    assign trap       = out_q.trap;
    assign trap_cause = out_q.trap_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds the expected per-cycle control trace of
// each instruction from the instruction-level rules and replays it.
module tb_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 5;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;
    localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                       7'b0100011, 7'b1100011, 7'b1101111,
                                       7'b1100111, 7'b0110111, 7'b0010111};
    localparam logic [2:0] IMMS [9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2,
                                        3'd4, 3'd0, 3'd3, 3'd3};

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [2:0] imm_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } outv_t;

    typedef struct {
        outv_t      o;
        logic       irdy;
        logic       drdy;
        logic       tk;
        logic [6:0] op;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       branch_taken = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic       alu_src_a, alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       retire, trap;
    logic [1:0] trap_cause;

    int   compared = 0;
    int   failed   = 0;
    cyc_t q[$];
    logic       carry_we  = 1'b0;
    logic [1:0] carry_src = 2'd0;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic outv_t sample();
        outv_t v;
        v = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, imm_sel,
             alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, retire, trap, trap_cause};
        return v;
    endfunction

    function automatic int cls_of(input logic [6:0] op);
        for (int k = 0; k < 9; k++) if (OPS[k] == op) return k;
        return -1;
    endfunction

    task automatic push(input outv_t o, input logic irdy, input logic drdy,
                        input logic tk, input logic [6:0] op);
        cyc_t c;
        c.o = o; c.irdy = irdy; c.drdy = drdy; c.tk = tk; c.op = op;
        q.push_back(c);
    endtask

    task automatic add_trap(input logic [1:0] cause, input int n);
        outv_t o;
        for (int k = 0; k < n; k++) begin
            o = '0; o.trap = 1'b1; o.trap_cause = cause;
            push(o, 1'b0, 1'b0, 1'b0, 7'd0);
        end
    endtask

    // Fetch waits idly cycles then sees ready; hang means ready never comes.
    task automatic add_fetch(input int idly, input logic [6:0] op, input bit hang);
        outv_t o;
        int    n;
        n = hang ? MEM_TIMEOUT : idly + 1;
        for (int k = 0; k < n; k++) begin
            o = '0; o.imem_req = 1'b1;
            if (k == 0) begin
                o.pc_we = carry_we; o.pc_src = carry_src; o.retire = carry_we;
            end
            push(o, !hang && (k == n - 1), 1'b0, 1'b0, op);
        end
        carry_we = 1'b0; carry_src = 2'd0;
    endtask

    task automatic add_instr(input logic [6:0] op, input int idly, input int ddly,
                             input logic tk, input bit dhang);
        outv_t o;
        int    c, n;
        c = cls_of(op);
        add_fetch(idly, op, 1'b0);
        o = '0; o.ir_we = 1'b1;
        push(o, 1'b0, 1'b0, tk, op);
        if (c < 0) begin
            add_trap(2'd1, 20);
            return;
        end
        o = '0; o.imm_sel = IMMS[c];
        case (c)
            K_R:      o.alu_op = 2'd2;
            K_I:      begin o.alu_src_b = 1'b1; o.alu_op = 2'd2; end
            K_LOAD, K_STORE: o.alu_src_b = 1'b1;
            K_LUI:    o.alu_op = 2'd3;
            K_AUIPC:  begin o.alu_src_a = 1'b1; o.alu_src_b = 1'b1; end
            K_BRANCH: o.alu_op = 2'd1;
            K_JAL:    begin o.pc_we = 1'b1; o.pc_src = 2'd1; end
            K_JALR:   begin o.pc_we = 1'b1; o.pc_src = 2'd2; end
            default: ;
        endcase
        push(o, 1'b0, 1'b0, tk, op);
        if (c == K_LOAD || c == K_STORE) begin
            n = dhang ? MEM_TIMEOUT : ddly + 1;
            for (int k = 0; k < n; k++) begin
                o = '0; o.dmem_req = 1'b1; o.dmem_we = (c == K_STORE); o.imm_sel = IMMS[c];
                push(o, 1'b0, !dhang && (k == n - 1), tk, op);
            end
            if (dhang) begin
                add_trap(2'd3, 20);
                return;
            end
        end
        if (c == K_BRANCH) begin
            carry_we = 1'b1; carry_src = tk ? 2'd1 : 2'd0;
        end else if (c == K_STORE) begin
            carry_we = 1'b1; carry_src = 2'd0;
        end else begin
            o = '0; o.reg_we = 1'b1; o.retire = 1'b1; o.imm_sel = IMMS[c];
            o.wb_sel = (c == K_LOAD) ? 2'd1 : (c == K_JAL || c == K_JALR) ? 2'd2 : 2'd0;
            o.pc_we  = !(c == K_JAL || c == K_JALR);
            push(o, 1'b0, 1'b0, tk, op);
        end
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run(input int n, input string tag);
        cyc_t  c;
        outv_t obs;
        int    i;
        i = 0;
        while (q.size() > 0 && (n < 0 || i < n)) begin
            c = q.pop_front();
            imem_ready = c.irdy; dmem_ready = c.drdy; branch_taken = c.tk; opcode = c.op;
            @(negedge clk);
            obs = sample();
            compared++;
            assert (obs === c.o) else begin
                failed++;
                $error("FAIL %s cyc %0d: got %h want %h", tag, i, obs, c.o);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic do_reset(input string tag, input bit check_now);
        outv_t obs;
        rst_n = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
        if (check_now) begin
            #1;
            obs = sample();
            compared++;
            assert (obs === outv_t'(0)) else begin
                failed++;
                $error("FAIL %s_async: got %h want 0", tag, obs);
            end
        end
        q.delete();
        carry_we = 1'b0; carry_src = 2'd0;
        @(posedge clk); @(posedge clk); #1;
        obs = sample();
        compared++;
        assert (obs === outv_t'(0)) else begin
            failed++;
            $error("FAIL %s_held: got %h want 0", tag, obs);
        end
        rst_n = 1'b1;
        push('0, 1'b0, 1'b0, 1'b0, 7'd0);
        run(-1, {tag, "_idle"});
    endtask

    initial begin
        do_reset("reset", 1'b0);

        add_instr(OPS[K_R], 0, 0, 1'b0, 1'b0);      run(-1, "r_type");
        add_instr(OPS[K_LOAD], 0, 3, 1'b0, 1'b0);   run(-1, "load_d3");
        add_instr(OPS[K_STORE], 1, 0, 1'b0, 1'b0);  run(-1, "store");
        add_instr(OPS[K_BRANCH], 0, 0, 1'b1, 1'b0); run(-1, "br_taken");
        add_instr(OPS[K_BRANCH], 0, 0, 1'b0, 1'b0); run(-1, "br_not");
        add_instr(OPS[K_JAL], 0, 0, 1'b0, 1'b0);    run(-1, "jal");
        add_instr(OPS[K_JALR], 2, 0, 1'b1, 1'b0);   run(-1, "jalr");
        add_instr(OPS[K_LUI], 0, 0, 1'b0, 1'b0);    run(-1, "lui");
        add_instr(OPS[K_AUIPC], 0, 0, 1'b0, 1'b0);  run(-1, "auipc");
        add_instr(OPS[K_I], 0, 0, 1'b0, 1'b0);      run(-1, "i_alu");

        for (int k = 0; k < 40; k++) begin
            add_instr(OPS[$urandom_range(0, 8)], int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            run(-1, "random");
        end

        add_instr(OPS[K_LOAD], MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, 1'b0);
        run(-1, "late_ready");
        add_instr(OPS[K_STORE], 0, MEM_TIMEOUT - 1, 1'b0, 1'b0);
        run(-1, "late_store");
        add_instr(OPS[K_R], 0, 0, 1'b0, 1'b0);
        run(-1, "drain");

        add_instr(7'b0000000, 0, 0, 1'b0, 1'b0);    run(-1, "illegal_00");
        do_reset("rst_after_illegal", 1'b0);
        add_instr(7'b0110010, 1, 0, 1'b0, 1'b0);    run(-1, "illegal_lowbits");
        do_reset("rst_after_illegal2", 1'b0);

        add_fetch(0, 7'd0, 1'b1);
        add_trap(2'd2, 20);
        run(-1, "imem_timeout");
        do_reset("rst_after_imem", 1'b0);

        add_instr(OPS[K_LOAD], 0, 0, 1'b0, 1'b1);   run(-1, "dmem_timeout");
        do_reset("rst_after_dmem", 1'b0);

        add_instr(OPS[K_STORE], 0, 5, 1'b0, 1'b0);
        run(5, "store_pre_rst");
        #2;
        do_reset("rst_mid_mem", 1'b1);
        add_instr(OPS[K_R], 0, 0, 1'b0, 1'b0);      run(-1, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Drives the immediate-select, ALU, PC, register-file and memory controls, and performs valid/ready handshakes with instruction and data memory.
- Traps on illegal opcodes and on memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait for ready before trapping (must be at least 1).
- CNT_W, 5: width of the wait counter (must satisfy 2^CNT_W > MEM_TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  IR[6:0] from the instruction register.
- branch_taken  input  1  branch compare result from the ALU, valid in EXEC.
- imem_ready  input  1  instruction memory data valid.
- dmem_ready  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- ir_we  output  1  instruction register write enable.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write (1 = store).
- pc_we  output  1  PC write enable.
- pc_src  output  2  next-PC select: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- imm_sel  output  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- alu_src_a  output  1  ALU operand A select: 0 = rs1, 1 = PC.
- alu_src_b  output  1  ALU operand B select: 0 = rs2, 1 = imm.
- alu_op  output  2  ALU operation: 0 = add, 1 = compare (branch), 2 = funct-decoded, 3 = pass B (LUI).
- reg_we  output  1  register file write enable.
- wb_sel  output  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- retire  output  1  one-cycle pulse when an instruction completes.
- trap  output  1  sticky fault flag.
- trap_cause  output  2  fault cause: 0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, wait counter = 0, latched opcode = 0.
- All outputs are registered and are 0 during reset.
- Reset asserted mid-instruction aborts it immediately; no pc_we or reg_we pulse occurs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE -> FETCH unconditionally (one cycle after reset release).
- FETCH: imem_req = 1 is held until imem_ready is sampled 1.
  - On ready: ir_we pulses for exactly that cycle, counter clears, next state is DECODE.
  - If the counter reaches MEM_TIMEOUT with no ready: TRAP, cause 2.
- DECODE: latch opcode and set imm_sel from the opcode class.
  - Unknown opcode -> TRAP, cause 1. Bits [1:0] != 2'b11 are illegal.
- EXEC, per class:
  - R: alu_src_b = 0, alu_op = 2.
  - I-ALU: alu_src_b = 1, alu_op = 2.
  - LOAD/STORE: alu_src_b = 1, alu_op = 0.
  - LUI: alu_op = 3.
  - AUIPC: alu_src_a = 1, alu_src_b = 1, alu_op = 0.
  - BRANCH: alu_op = 1, then pc_we = 1 with pc_src = 1 if branch_taken, else 0. Next state FETCH, retire = 1.
  - JAL: pc_src = 1, pc_we = 1. Next state WB.
  - JALR: pc_src = 2, pc_we = 1. Next state WB.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM: dmem_req = 1 held until dmem_ready; dmem_we = 1 for STORE.
  - On ready: STORE -> FETCH with pc_we = 1, pc_src = 0, retire = 1. LOAD -> WB.
  - On timeout: TRAP, cause 3.
- WB: reg_we = 1 for one cycle.
  - wb_sel = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_we = 1 with pc_src = 0, except JAL/JALR (PC already written in EXEC).
  - retire = 1. Next state FETCH.
- TRAP is absorbing: trap = 1, cause held, all enables 0. Exit only by reset.
- Minimum cycles per instruction: branch 3, store 4, ALU/jump 4, load 5, plus memory wait cycles.
- Counter: increments each waiting cycle and saturates. A ready arriving on the same cycle the counter hits MEM_TIMEOUT takes priority, so no trap occurs.
- Only one of pc_we / reg_we / dmem_req is issued per cycle, except WB, where pc_we and reg_we may both be asserted.
- Opcode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.

Decomposition:
- ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - the imm_sel, pc_src, alu_op, wb_sel and trap_cause encodings.
- Sub-module opcode_class_dec: combinational mapping of 7-bit opcode to a one-hot class vector plus legal flag, and the imm_sel value.
  - Reused by the FSM and the verification scoreboard.

Test Plan:
- R-type 0110011 with imem_ready immediate: after reset, FETCH, DECODE, EXEC, WB at cycles 1-4 with reg_we = 1 and wb_sel = 0 in WB; retire pulses once; 4 cycles per instruction.
- LOAD with dmem_ready delayed 3 cycles: dmem_req is held 4 cycles with dmem_we = 0; then WB with wb_sel = 1 and reg_we = 1; total 8 cycles.
- STORE then BRANCH:
  - STORE: dmem_we = 1, no reg_we, pc_we with pc_src = 0.
  - BRANCH with branch_taken = 1: pc_src = 1 in EXEC. Repeated with branch_taken = 0: pc_src = 0.
  - imm_sel is 1, then 2.
- JAL 1101111: imm_sel = 4; pc_we with pc_src = 1 in EXEC; WB has reg_we = 1, wb_sel = 2, no second pc_we.
- Opcode 0000000 -> TRAP with cause 1; imem_ready held 0 for MEM_TIMEOUT cycles -> cause 2. trap stays 1 for 20 further cycles and clears only on rst_n.
- rst_n pulsed low during MEM of a store: all outputs 0 asynchronously, no retire; restart from IDLE -> FETCH.
